sram_controller: RTL
====================

Name: sram_controller

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Services 32-bit data-memory reads and writes against an external 16-bit asynchronous SRAM, using two half-word accesses per word.
- Produces `ready`. The top level drives the pipeline `freeze = ~ready` into all pipeline registers, including EX/MEM, so the pipeline holds while an access is in flight.
- Returns read data to the MEM/WB register.

Parameters:
- ADDR_BASE, 1024: data-memory base address, subtracted from the CPU byte address.
- SRAM_AW, 18: SRAM half-word address width.
- SRAM_WAIT, 2: clock cycles held per half-word access (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- memREn  input  1  read request (from EX/MEM memREnOut).
- memWEn  input  1  write request (from EX/MEM memWEnOut).
- addr  input  32  CPU byte address (EX/MEM aluResOut).
- wrData  input  32  store data (EX/MEM valRmOut).
- rdData  output  32  registered load result.
- ready  output  1  1 = no access pending or access complete; 0 = stall.
- sramAddr  output  SRAM_AW  SRAM half-word address.
- sramDq  inout  16  SRAM data bus; driven only during write phases, else high-Z.
- sramWeN  output  1  SRAM write enable, active low.
- sramOeN  output  1  SRAM output enable, active low.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, wait counter = 0.
  - rdData = 0, sramAddr = 0, sramWeN = 1, sramOeN = 1, sramDq = Z.
  - ready = 1 (no request asserted).
- Address mapping:
  - wordAddr = (addr − ADDR_BASE) >> 2, 32-bit unsigned subtract.
  - Low half uses sramAddr = {wordAddr[SRAM_AW-2:0], 1'b0}; high half uses {wordAddr[SRAM_AW-2:0], 1'b1}.
  - Upper bits are discarded; addresses below ADDR_BASE wrap, with no error.
- Request rules:
  - A request is memREn | memWEn.
  - If both are set, treat it as a write; memREn is ignored.
- States and transitions:
  - IDLE:
    - ready = ~(memREn | memWEn), combinational.
    - On a request: latch wordAddr, wrData and the op type (write/read) into internal registers, clear the counter, go to LO.
    - With no request: stay in IDLE with all SRAM strobes inactive.
  - LO:
    - sramAddr = low-half address.
    - Write: sramWeN = 0, sramDq = latched data[15:0].
    - Read: sramOeN = 0, sramDq = Z.
    - Counter increments each cycle.
    - On the last cycle (counter = SRAM_WAIT−1): a read captures sramDq into rdData[15:0]; go to HI and clear the counter.
  - HI:
    - Same as LO, using the high-half address and data[31:16]; a read captures into rdData[31:16].
    - On the last cycle, go to DONE.
  - DONE:
    - ready = 1 for exactly one cycle; strobes inactive.
    - Next state is IDLE unconditionally.
- Stall length: ready is low from the request-accept cycle through the end of HI, i.e. 1 + 2·SRAM_WAIT cycles; ready is high in the following (DONE) cycle. With the default: 5 stall cycles, ready high on the 6th.
- Request lifetime:
  - The EX/MEM register loads on the DONE edge, so the request seen in the next IDLE belongs to the next instruction.
  - Back-to-back memory instructions each take the full sequence.
- Mid-operation changes: any change on memREn/memWEn/addr/wrData after acceptance is ignored. The operation completes using the latched values.
- rdData:
  - Holds its value except at read capture points.
  - Writes do not modify rdData.
  - A completed read's rdData is stable from DONE onward.
- Reset mid-operation: abort immediately, return to IDLE with the reset values above. A partially written word in the SRAM is acceptable.
- SRAM_WAIT = 1: each phase is a single cycle that is both first and last.

Decomposition:
- Shared package (mem_pkg):
  - state enum IDLE/LO/HI/DONE, 2 bits;
  - ADDR_BASE default;
  - OP_READ/OP_WRITE encoding.
- Sub-module: sram_wait_counter, a clearable up-counter with a `last` output at SRAM_WAIT−1, instantiated once.
- Latches reuse the existing parameterised Register with ld = accept and clr = 0.

Test Plan:
- Reset, then hold rst for 3 cycles with no request → ready = 1, sramWeN = 1, sramOeN = 1, sramDq = Z, rdData = 0.
- Write with addr = 1024, wrData = 0xDEADBEEF:
  - SRAM model sees addr 0 = 0xBEEF and addr 1 = 0xDEAD, each with sramWeN low for 2 cycles.
  - ready is low for 5 cycles, then high for 1 cycle.
- Read of addr = 1024 after the above → rdData = 0xDEADBEEF in the DONE cycle; ready pulse timing identical to the write.
- Write addr = 1028 (0x12345678), then read addr = 1028 with requests held continuously → two full sequences; sramAddr = 2/3 for both; final rdData = 0x12345678.
- memREn = memWEn = 1 at addr = 1032, wrData = 0xA5A5A5A5 → performed as a write: SRAM addr 4/5 = 0xA5A5; rdData unchanged.
- Start a write of 0xCAFEF00D at addr 1036, assert rst during HI → immediate IDLE, strobes inactive, dq = Z, rdData = 0. The next read request then completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory SRAM controller
package mem_pkg;

   // Controller phases: idle, low half-word, high half-word, completion pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } memState_t;

   // Latched operation type; a simultaneous read+write request is stored as a write
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } memOp_t;

   localparam int unsigned ADDR_BASE_DEF = 32'd1024;

endpackage

// File: rtl/Register.sv
// rtl/Register.sv - parameterised load/clear register with asynchronous reset
module Register #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear has priority over load; reset forces zero immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - clearable cycle counter flagging the last cycle of an SRAM phase
module sram_wait_counter #(
   parameter int unsigned SRAM_WAIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic last
);

   localparam int unsigned CW = $clog2(SRAM_WAIT + 1);

   logic [CW-1:0] count;

   // Counts cycles within a phase; cleared between phases and while not accessing
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   // With SRAM_WAIT = 1 the count never leaves zero, so every phase cycle is the last
   always_comb begin
      last = (count == CW'(SRAM_WAIT - 1));
   end

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage access to a 16-bit async SRAM in two half-word phases
module sram_controller
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_BASE = ADDR_BASE_DEF,
   parameter int unsigned SRAM_AW   = 18,
   parameter int unsigned SRAM_WAIT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               memREn,
   input  logic               memWEn,
   input  logic [31:0]        addr,
   input  logic [31:0]        wrData,
   output logic [31:0]        rdData,
   output logic               ready,
   output logic [SRAM_AW-1:0] sramAddr,
   inout  tri   [15:0]        sramDq,
   output logic               sramWeN,
   output logic               sramOeN
);

   memState_t state, nextState;

   logic                request;
   logic                accept;
   logic [31:0]         offset;
   logic [SRAM_AW-2:0]  wordAddrLo;
   logic                unusedBits;
   logic [SRAM_AW-2:0]  latAddr;
   logic [31:0]         latData;
   logic [0:0]          latOp;
   logic                isWrite;
   logic                waitClr;
   logic                waitLast;
   logic                phaseHi;
   logic                driveDq;
   logic [15:0]         dqOut;
   logic                capLo;
   logic                capHi;

   assign request    = memREn | memWEn;
   assign accept     = (state == IDLE) && request;
   // Below-base addresses wrap through the unsigned subtract; upper bits are dropped
   assign offset     = addr - 32'(ADDR_BASE);
   assign wordAddrLo = offset[SRAM_AW:2];
   assign unusedBits = ^{offset[31:SRAM_AW+1], offset[1:0]};
   assign isWrite    = (memOp_t'(latOp[0]) == OP_WRITE);

   Register #(.W(SRAM_AW-1)) addrReg (
      .clk (clk), .rst (rst), .ld (accept), .clr (1'b0), .d (wordAddrLo), .q (latAddr)
   );

   Register #(.W(32)) dataReg (
      .clk (clk), .rst (rst), .ld (accept), .clr (1'b0), .d (wrData), .q (latData)
   );

   Register #(.W(1)) opReg (
      .clk (clk), .rst (rst), .ld (accept), .clr (1'b0),
      .d   (memWEn ? OP_WRITE : OP_READ), .q (latOp)
   );

   // Restart the phase count on entry to each half-word phase
   assign waitClr = !((state == LO) || (state == HI)) || waitLast;

   sram_wait_counter #(.SRAM_WAIT(SRAM_WAIT)) waitCnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (waitClr),
      .last (waitLast)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state logic: each accepted request runs LO, HI, DONE regardless of later inputs
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (request)  nextState = LO;
         LO:   if (waitLast) nextState = HI;
         HI:   if (waitLast) nextState = DONE;
         DONE:               nextState = IDLE;
         default:            nextState = IDLE;
      endcase
   end

   // Output decode: strobes, data drive, read capture points and the ready flag
   always_comb begin
      ready   = 1'b0;
      sramWeN = 1'b1;
      sramOeN = 1'b1;
      driveDq = 1'b0;
      phaseHi = 1'b0;
      dqOut   = latData[15:0];
      capLo   = 1'b0;
      capHi   = 1'b0;
      case (state)
         IDLE: ready = ~request;
         LO: begin
            if (isWrite) begin
               sramWeN = 1'b0;
               driveDq = 1'b1;
            end else begin
               sramOeN = 1'b0;
               capLo   = waitLast;
            end
         end
         HI: begin
            phaseHi = 1'b1;
            dqOut   = latData[31:16];
            if (isWrite) begin
               sramWeN = 1'b0;
               driveDq = 1'b1;
            end else begin
               sramOeN = 1'b0;
               capHi   = waitLast;
            end
         end
         DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign sramAddr = {latAddr, phaseHi};
   assign sramDq   = driveDq ? dqOut : 16'hzzzz;

   // Load result only changes at the last cycle of each read phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdData <= '0;
      end else begin
         if (capLo) rdData[15:0]  <= sramDq;
         if (capHi) rdData[31:16] <= sramDq;
      end
   end

endmodule
